// File: rtl/a51_keystream_gen.sv
// ---------------------------------------------------------------------------
// a51_keystream_gen
//
// Self-sequencing A5/1 keystream generator. A run parallel-loads a key and a
// frame number, shifts them bit-serially into the three LFSRs (KEY and FRAME
// phases, all registers stepping), runs MIX_CYCLES majority-clocked warm-up
// steps whose output is thrown away, then produces KS_BITS keystream bits.
// The bits are packed OUT_W at a time (earliest bit in the MSB) and offered
// on a valid/ready stream.
//
// Handshake: ks_word/ks_last are stable while ks_valid is high; a word is
// consumed on a rising edge where ks_valid & ks_ready. A new word may be
// loaded on the same edge the previous one is consumed, so there is no
// bubble between words.
//
// Optional feature (macro A51_FRAME_AUTOINC_EN): after the final word of a
// run is accepted the generator restarts on its own with frame_cur + 1 and
// the latched key, and only abort/reset bring it back to IDLE. With the
// macro undefined the generator returns to IDLE after each run.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request a run (sampled only in IDLE)
//   abort      in   synchronous cancel of any run
//   key        in   KEY_BITS key, bit 0 shifted in first
//   frame      in   FRAME_BITS frame number, bit 0 shifted in first
//   busy       out  high in every state except IDLE
//   ks_valid   out  ks_word holds an unconsumed word
//   ks_ready   in   consumer ready
//   ks_word    out  OUT_W packed keystream bits, earliest bit in MSB
//   ks_last    out  marks the final word of a run
//   done       out  one-cycle pulse following acceptance of the final word
//   frame_cur  out  frame number used by the current/last run
//   dbg_state  out  FSM state for observation
// ---------------------------------------------------------------------------
module a51_keystream_gen #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int KS_BITS    = 228,
    parameter int OUT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic [OUT_W-1:0]      ks_word,
    output logic                  ks_last,
    output logic                  done,
    output logic [FRAME_BITS-1:0] frame_cur,
    output logic [2:0]            dbg_state
);

    localparam int MAX_KF  = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int MAX_MK  = (MIX_CYCLES > KS_BITS) ? MIX_CYCLES : KS_BITS;
    localparam int MAX_LEN = (MAX_KF > MAX_MK) ? MAX_KF : MAX_MK;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int N_WORDS = KS_BITS / OUT_W;
    localparam int WCNT_W  = $clog2(N_WORDS + 1);
    localparam int PCNT_W  = $clog2(OUT_W + 1);

    if ((KS_BITS % OUT_W) != 0) begin : g_bad_ks_bits
        $error("KS_BITS must be a multiple of OUT_W");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_FRAME = 3'd2,
        S_MIX   = 3'd3,
        S_GEN   = 3'd4
    } state_t;

    // One LFSR step: shift toward the MSB, feedback (plus optional load bit)
    // enters bit 0.
    function automatic logic [18:0] step_r1(input logic [18:0] r, input logic in_bit);
        return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13] ^ in_bit};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r, input logic in_bit);
        return {r[20:0], r[21] ^ r[20] ^ in_bit};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r, input logic in_bit);
        return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7] ^ in_bit};
    endfunction

    state_t                state_q, state_d;
    logic [18:0]           r1_q, r1_d;
    logic [21:0]           r2_q, r2_d;
    logic [22:0]           r3_q, r3_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [FRAME_BITS-1:0] frame_sh_q, frame_sh_d;
    logic [FRAME_BITS-1:0] frame_cur_q, frame_cur_d;
    logic [OUT_W-1:0]      pack_q, pack_d;
    logic [PCNT_W-1:0]     pack_cnt_q, pack_cnt_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [OUT_W-1:0]      ks_word_q, ks_word_d;
    logic                  ks_valid_q, ks_valid_d;
    logic                  ks_last_q, ks_last_d;
    logic                  done_q, done_d;

    // Majority-clocked step, shared by MIX and GEN.
    logic        maj;
    logic [18:0] r1_maj;
    logic [21:0] r2_maj;
    logic [22:0] r3_maj;
    logic        z_maj;

    assign maj    = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    assign r1_maj = (r1_q[8]  == maj) ? step_r1(r1_q, 1'b0) : r1_q;
    assign r2_maj = (r2_q[10] == maj) ? step_r2(r2_q, 1'b0) : r2_q;
    assign r3_maj = (r3_q[10] == maj) ? step_r3(r3_q, 1'b0) : r3_q;
    assign z_maj  = r1_maj[18] ^ r2_maj[21] ^ r3_maj[22];

    logic             pack_full;
    logic             accept;
    logic             xfer;
    logic             gen_step;
    logic [OUT_W-1:0] pack_base;

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        frame_sh_d  = frame_sh_q;
        frame_cur_d = frame_cur_q;
        pack_d      = pack_q;
        pack_cnt_d  = pack_cnt_q;
        wcnt_d      = wcnt_q;
        ks_word_d   = ks_word_q;
        ks_valid_d  = ks_valid_q;
        ks_last_d   = ks_last_q;
        done_d      = 1'b0;
        pack_full   = (pack_cnt_q == PCNT_W'(OUT_W));
        accept      = ks_valid_q & ks_ready;
        xfer        = 1'b0;
        gen_step    = 1'b0;
        pack_base   = pack_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d       = key;
                    frame_sh_d  = frame;
                    frame_cur_d = frame;
                    r1_d        = '0;
                    r2_d        = '0;
                    r3_d        = '0;
                    cnt_d       = '0;
                    pack_d      = '0;
                    pack_cnt_d  = '0;
                    wcnt_d      = '0;
                    state_d     = S_KEY;
                end
            end

            S_KEY: begin
                r1_d = step_r1(r1_q, key_q[0]);
                r2_d = step_r2(r2_q, key_q[0]);
                r3_d = step_r3(r3_q, key_q[0]);
                // Rotate rather than shift: after KEY_BITS steps the latched
                // key is intact again, so an auto-restarted run can reuse it.
                key_d = (key_q >> 1) | (key_q << (KEY_BITS - 1));
                if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FRAME: begin
                r1_d       = step_r1(r1_q, frame_sh_q[0]);
                r2_d       = step_r2(r2_q, frame_sh_q[0]);
                r3_d       = step_r3(r3_q, frame_sh_q[0]);
                frame_sh_d = frame_sh_q >> 1;
                if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_MIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_MIX: begin
                r1_d = r1_maj;
                r2_d = r2_maj;
                r3_d = r3_maj;
                if (cnt_q == CNT_W'(MIX_CYCLES - 1)) begin
                    cnt_d      = '0;
                    pack_cnt_d = '0;
                    wcnt_d     = '0;
                    state_d    = S_GEN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GEN: begin
                // A full pack may move out when the output slot is empty or
                // being emptied this cycle. While it cannot, the LFSRs hold so
                // no keystream bit is lost.
                xfer     = pack_full & (~ks_valid_q | ks_ready);
                gen_step = (cnt_q != CNT_W'(KS_BITS)) & (~pack_full | xfer);

                if (accept) begin
                    ks_valid_d = 1'b0;
                    ks_last_d  = 1'b0;
                end

                if (xfer) begin
                    ks_word_d  = pack_q;
                    ks_valid_d = 1'b1;
                    ks_last_d  = (wcnt_q == WCNT_W'(N_WORDS - 1));
                    wcnt_d     = wcnt_q + WCNT_W'(1);
                    pack_cnt_d = '0;
                    pack_base  = '0;
                end

                if (gen_step) begin
                    r1_d       = r1_maj;
                    r2_d       = r2_maj;
                    r3_d       = r3_maj;
                    pack_d     = (pack_base << 1) | OUT_W'(z_maj);
                    pack_cnt_d = (xfer ? PCNT_W'(0) : pack_cnt_q) + PCNT_W'(1);
                    cnt_d      = cnt_q + CNT_W'(1);
                end

                if (accept & ks_last_q) begin
                    done_d = 1'b1;
`ifdef A51_FRAME_AUTOINC_EN
                    // Continuous framing: next frame number, same key.
                    frame_cur_d = frame_cur_q + FRAME_BITS'(1);
                    frame_sh_d  = frame_cur_q + FRAME_BITS'(1);
                    r1_d        = '0;
                    r2_d        = '0;
                    r3_d        = '0;
                    cnt_d       = '0;
                    pack_d      = '0;
                    pack_cnt_d  = '0;
                    wcnt_d      = '0;
                    state_d     = S_KEY;
`else
                    state_d = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything above; frame_cur survives it.
        if (abort) begin
            state_d    = S_IDLE;
            r1_d       = '0;
            r2_d       = '0;
            r3_d       = '0;
            cnt_d      = '0;
            pack_d     = '0;
            pack_cnt_d = '0;
            wcnt_d     = '0;
            ks_word_d  = '0;
            ks_valid_d = 1'b0;
            ks_last_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            frame_sh_q  <= '0;
            frame_cur_q <= '0;
            pack_q      <= '0;
            pack_cnt_q  <= '0;
            wcnt_q      <= '0;
            ks_word_q   <= '0;
            ks_valid_q  <= 1'b0;
            ks_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            frame_sh_q  <= frame_sh_d;
            frame_cur_q <= frame_cur_d;
            pack_q      <= pack_d;
            pack_cnt_q  <= pack_cnt_d;
            wcnt_q      <= wcnt_d;
            ks_word_q   <= ks_word_d;
            ks_valid_q  <= ks_valid_d;
            ks_last_q   <= ks_last_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign ks_valid  = ks_valid_q;
    assign ks_word   = ks_word_q;
    assign ks_last   = ks_last_q;
    assign done      = done_q;
    assign frame_cur = frame_cur_q;
    assign dbg_state = state_q;

endmodule
